// File: rtl/lvt_pkg.sv
// Shared definitions for the live-value-table read port: default memory
// geometry and the write-snoop record used by both snoop ports.
package lvt_pkg;

   localparam int unsigned LVT_ADDR_W = 7;
   localparam int unsigned LVT_DATA_W = 5;

   // Snoop records are sized for the widest supported memory. Narrower ports
   // are zero-extended into them.
   localparam int unsigned LVT_SNP_ADDR_W = 16;
   localparam int unsigned LVT_SNP_DATA_W = 32;

   typedef struct packed {
      logic                      en;
      logic [LVT_SNP_ADDR_W-1:0] addr;
      logic [LVT_SNP_DATA_W-1:0] data;
   } lvt_wr_snoop_t;

   // True when a snooped write lands on the given address this cycle.
   function automatic logic lvt_snp_hit(input lvt_wr_snoop_t s,
                                        input logic [LVT_SNP_ADDR_W-1:0] a);
      return s.en && (s.addr == a);
   endfunction

endpackage

// File: rtl/lvt_resp_fifo.sv
// Small circular response buffer: push at the tail, present and pop the head.
// The requester's credit scheme keeps pushes from ever hitting a full buffer.
module lvt_resp_fifo #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             pop_ok;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign pop_ok    = pop && !empty;
   assign empty     = (count == '0);
   assign head_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop_ok)      count <= count + CNT_W'(1);
         else if (!push && pop_ok) count <= count - CNT_W'(1);
      end
   end

   // Entry storage; contents are meaningful only between push and pop.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/lvt_rd_port.sv
// Read-side requester for the 2-write/1-read live-value-table memory.
// Issues rd0 accesses from a valid/ready request stream, tracks the fixed
// read latency and buffers returned data behind a credit counter.
// Define LVT_RD_BYPASS_EN to let in-flight reads pick up snooped writes.
module lvt_rd_port
   import lvt_pkg::*;
#(
   parameter int unsigned ADDR_W = LVT_ADDR_W,
   parameter int unsigned DATA_W = LVT_DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              snp_wr0_en,
   input  logic [ADDR_W-1:0] snp_wr0_addr,
   input  logic [DATA_W-1:0] snp_wr0_data,
   input  logic              snp_wr1_en,
   input  logic [ADDR_W-1:0] snp_wr1_addr,
   input  logic [DATA_W-1:0] snp_wr1_data
);

   localparam int unsigned RESP_DEPTH = RD_LAT + 2;
   localparam int unsigned CRD_W      = $clog2(RESP_DEPTH + 1);

   logic [CRD_W-1:0]  credits_used;
   logic              accept;
   logic              pop;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              fifo_empty;
   logic [RD_LAT-1:0] stg_vld;

   lvt_wr_snoop_t snp0;
   lvt_wr_snoop_t snp1;
   logic          snp_unused;

   assign snp0 = '{en: snp_wr0_en, addr: LVT_SNP_ADDR_W'(snp_wr0_addr),
                   data: LVT_SNP_DATA_W'(snp_wr0_data)};
   assign snp1 = '{en: snp_wr1_en, addr: LVT_SNP_ADDR_W'(snp_wr1_addr),
                   data: LVT_SNP_DATA_W'(snp_wr1_data)};
   // Zero-extension bits (and, without bypass, the whole records) are sunk here.
   assign snp_unused = ^{snp0, snp1};

   // A response slot is reserved from accept until pop; no pop-through credit.
   assign req_ready   = rst && (credits_used < CRD_W'(RESP_DEPTH));
   assign accept      = req_valid && req_ready;
   assign mem_rd_en   = accept;
   assign mem_rd_addr = req_addr;
   assign resp_valid  = !fifo_empty;
   assign pop         = resp_valid && resp_ready;
   assign push        = stg_vld[RD_LAT-1];

   // In-flight valid pipeline; reset drops every outstanding read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_vld <= '0;
      end else begin
         stg_vld[0] <= accept;
         for (int unsigned i = 1; i < RD_LAT; i++) stg_vld[i] <= stg_vld[i-1];
      end
   end

   // Credit count: reserved on accept, released on pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_used <= '0;
      end else if (accept && !pop) begin
         credits_used <= credits_used + CRD_W'(1);
      end else if (!accept && pop) begin
         credits_used <= credits_used - CRD_W'(1);
      end
   end

`ifdef LVT_RD_BYPASS_EN
   logic [ADDR_W-1:0] stg_addr [RD_LAT];
   logic [RD_LAT-1:0] stg_hit;
   logic [DATA_W-1:0] stg_data [RD_LAT];
   logic              iss_hit;
   logic [DATA_W-1:0] iss_data;
   logic [RD_LAT-1:0] cur_hit;
   logic [DATA_W-1:0] cur_data [RD_LAT];

   // Fold this cycle's snooped writes into each read; wr1 is checked last so
   // it overrides wr0 on a same-address collision, as in the memory.
   always_comb begin
      iss_hit  = 1'b0;
      iss_data = '0;
      if (lvt_snp_hit(snp0, LVT_SNP_ADDR_W'(req_addr))) begin
         iss_hit  = 1'b1;
         iss_data = snp0.data[DATA_W-1:0];
      end
      if (lvt_snp_hit(snp1, LVT_SNP_ADDR_W'(req_addr))) begin
         iss_hit  = 1'b1;
         iss_data = snp1.data[DATA_W-1:0];
      end
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         cur_hit[i]  = stg_hit[i];
         cur_data[i] = stg_data[i];
         if (lvt_snp_hit(snp0, LVT_SNP_ADDR_W'(stg_addr[i]))) begin
            cur_hit[i]  = 1'b1;
            cur_data[i] = snp0.data[DATA_W-1:0];
         end
         if (lvt_snp_hit(snp1, LVT_SNP_ADDR_W'(stg_addr[i]))) begin
            cur_hit[i]  = 1'b1;
            cur_data[i] = snp1.data[DATA_W-1:0];
         end
      end
   end

   // Address and latched write data travel alongside the valid bit.
   always_ff @(posedge clk) begin
      stg_addr[0] <= req_addr;
      stg_hit[0]  <= iss_hit;
      stg_data[0] <= iss_data;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         stg_addr[i] <= stg_addr[i-1];
         stg_hit[i]  <= cur_hit[i-1];
         stg_data[i] <= cur_data[i-1];
      end
   end

   assign push_data = cur_hit[RD_LAT-1] ? cur_data[RD_LAT-1] : mem_rd_data;
`else
   assign push_data = mem_rd_data;
`endif

   lvt_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (DATA_W)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (resp_data),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_lvt_rd_port.sv
// Directed bench for lvt_rd_port with RD_LAT=1 against a small behavioural
// model of the lvt_bram memory (wr1 overrides wr0, one-cycle registered read).
module tb_lvt_rd_port;

   localparam int unsigned RD_LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_addr;
   logic       resp_valid;
   logic       resp_ready;
   logic [4:0] resp_data;
   logic       mem_rd_en;
   logic [6:0] mem_rd_addr;
   logic [4:0] mem_rd_data = '0;
   logic       snp_wr0_en;
   logic [6:0] snp_wr0_addr;
   logic [4:0] snp_wr0_data;
   logic       snp_wr1_en;
   logic [6:0] snp_wr1_addr;
   logic [4:0] snp_wr1_data;

   logic [4:0] mem [128] = '{default: '0};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lvt_rd_port #(
      .ADDR_W (7),
      .DATA_W (5),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .snp_wr0_en   (snp_wr0_en),
      .snp_wr0_addr (snp_wr0_addr),
      .snp_wr0_data (snp_wr0_data),
      .snp_wr1_en   (snp_wr1_en),
      .snp_wr1_addr (snp_wr1_addr),
      .snp_wr1_data (snp_wr1_data)
   );

   // Memory model: read returns the pre-edge contents; wr1 lands after wr0.
   always @(posedge clk) begin
      if (mem_rd_en)  mem_rd_data <= mem[mem_rd_addr];
      if (snp_wr0_en) mem[snp_wr0_addr] <= snp_wr0_data;
      if (snp_wr1_en) mem[snp_wr1_addr] <= snp_wr1_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Single read: checks issue, no early response, response at RD_LAT+1, pop.
   task automatic do_read(input string tag, input logic [6:0] a, input logic [4:0] e);
      req_valid = 1'b1;
      req_addr  = a;
      #1;
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
      chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'(a));
      tick();
      req_valid = 1'b0;
      #1;
      chk({tag, "_early"}, 32'(resp_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_data"}, 32'(resp_data), 32'(e));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      chk({tag, "_drained"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] exp_byp;
      logic [6:0] tp_addr [4];
      logic [4:0] tp_data [4];

      rst = 1'b0;
      req_valid = 1'b1; req_addr = 7'd3; resp_ready = 1'b0;
      snp_wr0_en = 1'b0; snp_wr0_addr = '0; snp_wr0_data = '0;
      snp_wr1_en = 1'b0; snp_wr1_addr = '0; snp_wr1_data = '0;
      tick(); tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_req_ready", 32'(req_ready), 32'd1);
      chk("rel_credits", 32'(dut.credits_used), 32'd0);

      // Basic read after a wr0 write
      snp_wr0_en = 1'b1; snp_wr0_addr = 7'd10; snp_wr0_data = 5'd5;
      tick();
      snp_wr0_en = 1'b0;
      do_read("basic", 7'd10, 5'd5);

      do_read("unwritten", 7'd95, 5'd0);

      // Backpressure with resp_ready low
      snp_wr0_en = 1'b1; snp_wr0_addr = 7'd20; snp_wr0_data = 5'd11;
      snp_wr1_en = 1'b1; snp_wr1_addr = 7'd30; snp_wr1_data = 5'd12;
      tick();
      snp_wr0_addr = 7'd40; snp_wr0_data = 5'd13;
      snp_wr1_addr = 7'd50; snp_wr1_data = 5'd14;
      tick();
      snp_wr0_en = 1'b0; snp_wr1_en = 1'b0;
      req_valid = 1'b1;
      req_addr = 7'd20; #1; chk("bp_rdy0", 32'(req_ready), 32'd1); tick();
      req_addr = 7'd30; #1; chk("bp_rdy1", 32'(req_ready), 32'd1); tick();
      req_addr = 7'd40; #1; chk("bp_rdy2", 32'(req_ready), 32'd1); tick();
      req_addr = 7'd50; #1;
      chk("bp_rdy3", 32'(req_ready), 32'd0);
      chk("bp_rd_en3", 32'(mem_rd_en), 32'd0);
      tick();
      chk("bp_full_rdy", 32'(req_ready), 32'd0);
      chk("bp_full_credits", 32'(dut.credits_used), 32'd3);
      tick();
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_data", 32'(resp_data), 32'd11);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      #1;
      chk("bp_pop0_data", 32'(resp_data), 32'd11);
      chk("bp_no_popthru", 32'(req_ready), 32'd0);
      tick();
      chk("bp_rdy_after_pop", 32'(req_ready), 32'd1);
      chk("bp_pop1_valid", 32'(resp_valid), 32'd1);
      chk("bp_pop1_data", 32'(resp_data), 32'd12);
      tick();
      chk("bp_pop2_valid", 32'(resp_valid), 32'd1);
      chk("bp_pop2_data", 32'(resp_data), 32'd13);
      tick();
      resp_ready = 1'b0;
      chk("bp_empty", 32'(resp_valid), 32'd0);
      chk("bp_credits", 32'(dut.credits_used), 32'd0);

      // Same-cycle writes to one address: wr1 wins
      snp_wr0_en = 1'b1; snp_wr0_addr = 7'd50; snp_wr0_data = 5'd25;
      snp_wr1_en = 1'b1; snp_wr1_addr = 7'd50; snp_wr1_data = 5'd30;
      tick();
      snp_wr0_en = 1'b0; snp_wr1_en = 1'b0;
      do_read("prio", 7'd50, 5'd30);

      // Write landing in the issue cycle of a read
      snp_wr0_en = 1'b1; snp_wr0_addr = 7'd50; snp_wr0_data = 5'd25;
      tick();
      snp_wr0_en = 1'b0;
`ifdef LVT_RD_BYPASS_EN
      exp_byp = 5'd40;
`else
      exp_byp = 5'd25;
`endif
      req_valid = 1'b1; req_addr = 7'd50;
      snp_wr1_en = 1'b1; snp_wr1_addr = 7'd50; snp_wr1_data = 5'd40;
      tick();
      req_valid = 1'b0; snp_wr1_en = 1'b0;
      tick();
      chk("byp_valid", 32'(resp_valid), 32'd1);
      chk("byp_data", 32'(resp_data), 32'(exp_byp));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

      // Reset with one response buffered and one read in flight
      req_valid = 1'b1; req_addr = 7'd10;
      tick();
      req_addr = 7'd20;
      #1;
      chk("mid_rdy", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_rdy", 32'(req_ready), 32'd0);
      chk("mid_rst_credits", 32'(dut.credits_used), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rel_rdy", 32'(req_ready), 32'd1);
      tick();
      chk("mid_rel_valid0", 32'(resp_valid), 32'd0);
      chk("mid_rel_credits", 32'(dut.credits_used), 32'd0);
      tick();
      chk("mid_rel_valid1", 32'(resp_valid), 32'd0);
      do_read("after_rst", 7'd10, 5'd5);

      // Back-to-back requests with resp_ready held high
      tp_addr[0] = 7'd10; tp_data[0] = 5'd5;
      tp_addr[1] = 7'd20; tp_data[1] = 5'd11;
      tp_addr[2] = 7'd30; tp_data[2] = 5'd12;
      tp_addr[3] = 7'd40; tp_data[3] = 5'd13;
      resp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) begin
            req_valid = 1'b1;
            req_addr  = tp_addr[i];
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (i < 4) chk($sformatf("tp_rdy%0d", i), 32'(req_ready), 32'd1);
         if (i >= 2 && i < 6) begin
            chk($sformatf("tp_valid%0d", i - 2), 32'(resp_valid), 32'd1);
            chk($sformatf("tp_data%0d", i - 2), 32'(resp_data), 32'(tp_data[i-2]));
         end
         if (i == 6) chk("tp_empty", 32'(resp_valid), 32'd0);
         tick();
      end
      resp_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
